// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns
// ({a,b,c,d,e,f,g}, a in bit 6, active-high) and the BCD digit width.
package seg7_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// BCD to seven-segment decoder, purely combinational and active-high.
// Codes 10..15 are not digits and light nothing.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Map one BCD code to its segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver. Each digit gets SCAN_DIV clock
// cycles; count 0 of every slot is dead time with no digit enabled. New
// values are loaded into a shadow register and copied into the display
// buffer only when the scan wraps back to digit 0, so a frame never tears.
// Optional feature: define SEG7_BLINK_EN to add the blink_mask input and
// a frame-counted blink phase.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int ACTIVE_LOW   = 0,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BCD_W*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]         dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
`ifdef SEG7_BLINK_EN
    input  logic [DIGITS-1:0]         blink_mask,
`endif
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [DIGITS-1:0]         dig_sel,
    output logic                      frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Reject parameter sets the scan timing cannot support.
    if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
        $error("seg7_scan_driver: illegal parameter value");
    end

    logic [CNT_W-1:0]          slot_cnt;
    logic [IDX_W-1:0]          dig_idx;
    logic [BCD_W*DIGITS-1:0]   shadow_bcd;
    logic [DIGITS-1:0]         shadow_dp;
    logic [BCD_W*DIGITS-1:0]   disp_bcd;
    logic [DIGITS-1:0]         disp_dp;
    logic [DIGITS-1:0]         lz_blank;
    logic [BCD_W-1:0]          cur_bcd;
    logic                      cur_dp;
    logic                      cur_off;
    logic [6:0]                dec_seg;
    logic [6:0]                seg_q;
    logic                      dp_q;
    logic [DIGITS-1:0]         sel_q;
    logic                      fd_q;
    logic                      slot_end;
    logic                      frame_wrap;

    assign slot_end   = (slot_cnt == CNT_LAST);
    assign frame_wrap = slot_end && (dig_idx == IDX_LAST);

    // Slot counter and digit index; the index advances when a slot ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            dig_idx  <= frame_wrap ? '0 : dig_idx + IDX_W'(1);
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // Shadow register follows every load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
        end
    end

    // Display buffer picks up the shadow only at the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd <= '0;
            disp_dp  <= '0;
        end else if (frame_wrap) begin
            disp_bcd <= shadow_bcd;
            disp_dp  <= shadow_dp;
        end
    end

    // Leading-zero mask: walk down from the top digit while digits are zero without dp.
    always_comb begin
        logic run;
        run      = 1'b1;
        lz_blank = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run = run && (disp_bcd[k*BCD_W +: BCD_W] == '0) && !disp_dp[k];
            if (k != 0) begin
                lz_blank[k] = run && blank_lz;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FCNT_W-1:0] frame_cnt;
    logic              blink_off;

    // Count completed frames and flip the blink phase every BLINK_FRAMES of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end
`endif

    // Select the digit currently being scanned and decide whether it is dark.
    always_comb begin
        cur_bcd = disp_bcd[dig_idx*BCD_W +: BCD_W];
        cur_dp  = disp_dp[dig_idx];
        cur_off = lz_blank[dig_idx];
`ifdef SEG7_BLINK_EN
        cur_off = cur_off || (blink_mask[dig_idx] && blink_off);
`endif
    end

    seg7_decode u_decode (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    // Output registers in active-high form; count 0 keeps every digit disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b0;
            sel_q <= '0;
            fd_q  <= 1'b0;
        end else begin
            seg_q <= cur_off ? SEG_BLANK : dec_seg;
            dp_q  <= cur_dp && !cur_off;
            sel_q <= (slot_cnt == '0) ? '0 : (DIGITS'(1) << dig_idx);
            fd_q  <= frame_wrap;
        end
    end

    assign seg_out    = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp_out     = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
    assign dig_sel    = (ACTIVE_LOW != 0) ? ~sel_q : sel_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter SCAN_DIV, default 1000, clock cycles per digit slot (>=2).
REQ-003 Parameter ACTIVE_LOW, default 0; 1 inverts seg_out, dp_out and dig_sel drive levels.
REQ-004 Parameter BLINK_FRAMES, default 64, frames per blink half-period; used only with SEG7_BLINK_EN.
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 bcd_in  input  4*DIGITS  BCD digits; digit 0 in [3:0] (least significant).
REQ-008 dp_in  input  DIGITS  decimal-point request per digit.
REQ-009 load  input  1  strobe; captures bcd_in/dp_in into shadow register.
REQ-010 blank_lz  input  1  enables leading-zero blanking.
REQ-011 seg_out  output  7  segments {a,b,c,d,e,f,g}, a in bit 6.
REQ-012 dp_out  output  1  decimal point of active digit.
REQ-013 dig_sel  output  DIGITS  one-hot digit enable.
REQ-014 frame_done  output  1  one-cycle pulse per completed scan frame.

Function
REQ-015 Segment codes (active-high, a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; codes 10-15 SHALL display all-off.
REQ-016 load high SHALL capture bcd_in/dp_in into shadow register on that edge; repeated loads overwrite.
REQ-017 Shadow SHALL transfer to display buffer only in the cycle digit index wraps DIGITS-1 -> 0 (tear-free); load in that same cycle SHALL reach display at the following wrap.
REQ-018 Slot counter SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and digit index increments, wrapping DIGITS-1 -> 0.
REQ-019 frame_done SHALL pulse high for exactly the cycle after index wraps to 0.
REQ-020 seg_out, dp_out, dig_sel SHALL be registered, valid one cycle after slot counter value they reflect.
REQ-021 During slot count 0 (dead time), dig_sel SHALL be all-inactive; counts 1..SCAN_DIV-1 assert dig_sel[index] only.
REQ-022 With blank_lz=1, digit k SHALL be blanked (segments and dp off) when it and all higher digits are 0 and dp not requested on any of them; digit 0 never blanked.
REQ-023 Blanked or invalid digits SHALL still receive their slot (constant frame timing).
REQ-024 ACTIVE_LOW=1 SHALL invert all three output groups, including reset and dead-time levels.

Reset
REQ-025 rst_n low SHALL immediately clear slot counter, index, shadow, display buffer, blink state; seg_out, dp_out, dig_sel at inactive level; frame_done 0.
REQ-026 Reset deassertion mid-frame SHALL restart at digit 0, count 0; first frame displays all zeros (blanked per blank_lz).

Configuration
REQ-027 Macro SEG7_BLINK_EN defined: input blink_mask [DIGITS-1:0] added; frame counter toggles blink phase every BLINK_FRAMES frames; masked digits fully off in off-phase, on-phase starts after reset.
REQ-028 SEG7_BLINK_EN undefined: blink_mask port, frame counter and phase logic absent; behaviour otherwise identical.

Structure
REQ-029 Package seg7_pkg SHALL hold segment pattern constants, SEG_BLANK constant and BCD width constant.
REQ-030 Sub-module seg7_decode SHALL implement REQ-015 combinationally; instantiated once on the muxed digit.

Verification
REQ-031 DIGITS=4, SCAN_DIV=4, load 0x1234 -> after next wrap slots show 4,3,2,1 segs 0110011,1111001,1101101,0110000 with dig_sel 0001,0010,0100,1000.
REQ-032 blank_lz=1, load 0x0070 -> digits 3,2 blank, digit1=1110000, digit0=1111110; load 0x0000 -> only digit0 shows 0.
REQ-033 Load 0x5678 mid-frame -> current frame unchanged; new value from next frame; frame_done pulses every 16 cycles.
REQ-034 ACTIVE_LOW=1, digit value 8 -> seg_out=0000000, dig_sel active bit 0; dead-time dig_sel=1111.
REQ-035 rst_n low at slot 2 count 3 -> outputs inactive immediately; after release index 0, count 0, display 0.
REQ-036 SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=0001 -> digit0 on frames 0-1, off 2-3, on 4-5; other digits constant.
